// File: rtl/cplxdiv_mulseq_if.sv
// cplxdiv_mulseq_if: operand, multiplier and result handshakes of the complex-divider operand sequencer
interface cplxdiv_mulseq_if #(
  parameter int DW = 16
);
  logic in_valid, in_ready;
  logic signed [DW-1:0] xr, xi, yr, yi;
  logic mul_run, mul_busy;
  logic signed [DW-1:0] mul_A, mul_B;
  logic signed [2*DW-1:0] mul_P;
  logic signed [2*DW:0] nr, ni;
  logic [2*DW:0] d;
  logic dz, out_valid, out_ready;
  modport slave (
    input in_valid, xr, xi, yr, yi, mul_busy, mul_P, out_ready,
    output in_ready, mul_run, mul_A, mul_B, nr, ni, d, dz, out_valid
  );
  modport master (
    output in_valid, xr, xi, yr, yi, mul_busy, mul_P, out_ready,
    input in_ready, mul_run, mul_A, mul_B, nr, ni, d, dz, out_valid
  );
endinterface

// File: rtl/cplxdiv_mulseq.sv
// cplxdiv_mulseq: time-shares one sequential multiplier to form Nr, Ni and D of a complex division
module cplxdiv_mulseq #(
  parameter int DW = 16
) (
  input logic clock,
  input logic reset,
  cplxdiv_mulseq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  state_t state, state_n;
  logic [2:0] k;
  logic signed [DW-1:0] xr, xi, yr, yi;
  logic signed [2*DW:0] acc_nr, acc_ni, acc_d, prod, nr_n, ni_n, d_n;
  logic capture;
  assign capture = state == WAIT_LO && !bus.mul_busy;
  assign prod = {bus.mul_P[2*DW-1], bus.mul_P};
  // k 0,1 -> nr; 2 adds / 3 subtracts -> ni; 4,5 -> d
  assign nr_n = k <= 3'd1 ? acc_nr + prod : acc_nr;
  assign ni_n = k == 3'd2 ? acc_ni + prod : k == 3'd3 ? acc_ni - prod : acc_ni;
  assign d_n = k >= 3'd4 ? acc_d + prod : acc_d;
  assign bus.mul_B = k[0] ? yi : yr;
  assign bus.mul_A = k >= 3'd4 ? bus.mul_B : (k == 3'd0 || k == 3'd3) ? xr : xi;
  assign bus.mul_run = state == ISSUE;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.in_valid ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT_HI;
      WAIT_HI: state_n = bus.mul_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_n = bus.mul_busy ? WAIT_LO : k == 3'd5 ? DONE : ISSUE;
      DONE:    state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      xr <= '0;
      xi <= '0;
      yr <= '0;
      yi <= '0;
      acc_nr <= '0;
      acc_ni <= '0;
      acc_d <= '0;
      bus.nr <= '0;
      bus.ni <= '0;
      bus.d <= '0;
      bus.dz <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        xr <= bus.xr;
        xi <= bus.xi;
        yr <= bus.yr;
        yi <= bus.yi;
        acc_nr <= '0;
        acc_ni <= '0;
        acc_d <= '0;
        k <= '0;
      end
      if (capture) begin
        acc_nr <= nr_n;
        acc_ni <= ni_n;
        acc_d <= d_n;
        k <= k == 3'd5 ? k : k + 3'd1;
        if (k == 3'd5) begin
          bus.nr <= nr_n;
          bus.ni <= ni_n;
          bus.d <= d_n;
          bus.dz <= d_n == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cplxdiv_mulseq.sv
// tb_cplxdiv_mulseq: random and directed operand sets scored against the complex-division formulas
module tb_cplxdiv_mulseq;
  localparam int DW = 16;
  logic clock = 0;
  logic reset = 0;
  always #5 clock = ~clock;
  cplxdiv_mulseq_if #(.DW(DW)) bus ();
  cplxdiv_mulseq #(.DW(DW)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {longint nr; longint ni; longint d; logic dz;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, runs = 0, ready_mode = 0, busy_cnt = 0;
  logic signed [2*DW-1:0] p_hold;
  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  function automatic int pick_len();
    return ($urandom_range(0, 7) == 0) ? $urandom_range(2, 40) : $urandom_range(2, 4);
  endfunction
  // behavioural multiplier: busy for a random span, product valid when busy falls
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mul_busy <= 1'b0;
      bus.mul_P <= '0;
      busy_cnt <= 0;
    end else if (bus.mul_run && !bus.mul_busy) begin
      bus.mul_busy <= 1'b1;
      busy_cnt <= pick_len();
      p_hold <= $signed(bus.mul_A) * $signed(bus.mul_B);
      bus.mul_P <= $urandom;
    end else if (bus.mul_busy) begin
      if (busy_cnt <= 1) begin
        bus.mul_busy <= 1'b0;
        bus.mul_P <= p_hold;
      end
      busy_cnt <= busy_cnt - 1;
    end
  end
  always @(posedge clock) begin
    #1;
    bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) runs = 0;
      if (bus.mul_run) begin
        runs++;
        chk("run_while_busy", longint'(bus.mul_busy), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: nr %0d with empty scoreboard", bus.nr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("nr", longint'(bus.nr), e.nr);
          chk("ni", longint'(bus.ni), e.ni);
          chk("d", longint'(bus.d), e.d);
          chk("dz", longint'(bus.dz), longint'(e.dz));
          chk("run_pulses", runs, 6);
        end
      end
    end
  end
  function automatic exp_t model(longint a, longint b, longint c, longint e);
    exp_t r;
    r.nr = a * c + b * e;
    r.ni = b * c - a * e;
    r.d = c * c + e * e;
    r.dz = r.d == 0;
    return r;
  endfunction
  task automatic send(logic signed [DW-1:0] a, logic signed [DW-1:0] b,
                      logic signed [DW-1:0] c, logic signed [DW-1:0] e);
    int t = 0;
    while (!bus.in_ready && t < 5000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      $display("FAIL accept_timeout: in_ready %0d, expected 1", bus.in_ready);
      $fatal(1, "accept timeout");
    end
    bus.xr = a;
    bus.xi = b;
    bus.yr = c;
    bus.yi = e;
    bus.in_valid = 1'b1;
    sb.push_back(model(longint'(a), longint'(b), longint'(c), longint'(e)));
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !bus.in_ready) && t < 5000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_timeout", longint'(sb.size()), 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_mul_run", longint'(bus.mul_run), 0);
    chk("rst_nr", longint'(bus.nr), 0);
    chk("rst_ni", longint'(bus.ni), 0);
    chk("rst_d", longint'(bus.d), 0);
    chk("rst_dz", longint'(bus.dz), 0);
    chk("rst_mul_A", longint'(bus.mul_A), 0);
    chk("rst_mul_B", longint'(bus.mul_B), 0);
  endtask
  initial begin
    #950000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.xr = '0;
    bus.xi = '0;
    bus.yr = '0;
    bus.yi = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals();
    reset = 1'b0;
    @(posedge clock);
    #1;
    send(3, 4, 1, 2);
    send(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
    send(-7, 0, 0, 0);
    drain();
    ready_mode = 1;
    @(posedge clock);
    #1;
    send(5, -6, 7, 8);
    t = 0;
    while (!bus.out_valid && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", longint'(bus.out_valid), 1);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      chk("bp_nr", longint'(bus.nr), -13);
      chk("bp_ni", longint'(bus.ni), -82);
      chk("bp_d", longint'(bus.d), 113);
      bus.in_valid = i == 5;
      bus.xr = 16'sd99;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    ready_mode = 0;
    send(2, 3, 4, 5);
    drain();
    send(100, 200, -300, 400);
    t = 0;
    while ((runs < 4 || !bus.mul_busy) && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("reached_k3", runs, 4);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(1, 1, 1, -1);
    drain();
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 15) == 0)
        send(-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767);
      else
        send($urandom, $urandom, $urandom, $urandom);
    end
    drain();
    ready_mode = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cplxdiv_mulseq.md
Name: cplxdiv_mulseq

Overview:
- Operand sequencer directly upstream of the 16x16 sequential signed multiplier top-level in the complex divider.
- Accepts one complex pair, X = xr + j·xi and Y = yr + j·yi.
- Time-shares the single multiplier through its run/busy handshake to form the six partial products.
- Accumulates them into the divider numerators and denominator: Nr = xr·yr + xi·yi, Ni = xi·yr − xr·yi, D = yr² + yi².
- Results feed the downstream real-division stage through a valid/ready handshake.

Parameters:
- DW, 16, operand width; must match the multiplier (product width 2·DW).

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept an operand set (high only in IDLE)
- xr, xi, yr, yi  in  DW each  signed two's-complement operands
- mul_run  out  1  one-cycle start pulse to the multiplier
- mul_busy  in  1  multiplier busy
- mul_A, mul_B  out  DW each  multiplier operands
- mul_P  in  2·DW  signed multiplier product
- nr, ni  out  2·DW+1 each  signed numerators
- d  out  2·DW+1  unsigned denominator (MSB always 0)
- dz  out  1  d == 0 (divide by zero)
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results

Behaviour:
- Reset (asynchronous, any state): state ← IDLE, k ← 0.
  - Outputs after reset: in_ready 1, mul_run 0, out_valid 0, nr/ni/d 0, dz 0, mul_A/mul_B 0.
  - Reset mid-sequence aborts the sequence; the multiplier is reset by the same line.
- IDLE: in_ready = 1.
  - When in_valid = 1, register xr/xi/yr/yi, clear the accumulators, set k ← 0, go to ISSUE.
- ISSUE: drive mul_A/mul_B from the product table at index k; mul_run = 1 for exactly this one cycle; go to WAIT_HI.
- WAIT_HI: wait for mul_busy = 1, then go to WAIT_LO.
- WAIT_LO: wait for mul_busy = 0.
  - On the falling-edge cycle (first cycle busy is low): sign-extend mul_P to 2·DW+1 and accumulate.
  - If k = 5 go to DONE; otherwise k ← k+1 and go to ISSUE.
- mul_A/mul_B hold stable from ISSUE until mul_P is captured.
- Product table:
  - k = 0: xr·yr, added to nr
  - k = 1: xi·yi, added to nr
  - k = 2: xi·yr, added to ni
  - k = 3: xr·yi, subtracted from ni
  - k = 4: yr·yr, added to d
  - k = 5: yi·yi, added to d
- DONE: out_valid = 1; nr/ni/d/dz hold stable.
  - Return to IDLE on the cycle out_ready = 1; out_valid drops the next cycle.
  - New operands are accepted no earlier than the cycle after out_valid falls.
- Output registers: nr/ni/d/dz update only on entry to DONE and keep their values through IDLE until the next DONE.
- Widths: accumulators are 2·DW+1 bits, so no overflow is possible.
  - Extremes: nr max +2^31 (xr = yr = xi = yi = −32768); ni range [−2^31+2^15, 2^31−2^15]; d max 2^31.
- dz = (d == 0), registered together with d.
- Latency in cycles: 1 (accept) + 6 × (ISSUE + multiplier busy time + 1) + 1.
- in_valid while not in IDLE is ignored; in_ready is 0 there.
- mul_busy already high in ISSUE or WAIT_HI is treated as the high phase.
- The block never issues mul_run while mul_busy = 1.

Test Plan:
- Basic: X = 3+j4, Y = 1+j2 → nr = 11, ni = −2, d = 5, dz = 0.
  - Check exactly 6 mul_run pulses, each followed by busy high/low.
- Extremes: all operands −32768 → nr = 2^31, ni = 0, d = 2^31, with no sign wrap.
- Negatives and zero divisor: X = −7+j0, Y = 0+j0 → nr = 0, ni = 0, d = 0, dz = 1.
- Backpressure: hold out_ready = 0 for 20 cycles → out_valid and outputs stay stable, in_ready = 0, and a pulsed in_valid is ignored.
  - Release out_ready → next operand set is accepted.
- Reset mid-operation: assert reset during WAIT_LO of k = 3.
  - Outputs return immediately to reset values.
  - The next transaction X = 1+j1, Y = 1−j1 → nr = 0, ni = 2, d = 2.
- Back-to-back random: 1000 random operand pairs with a behavioural multiplier of random busy length (2–40 cycles), compared against the reference formulas.
